// File: rtl/cim_pkg.sv
// rtl/cim_pkg.sv - shared types and defaults for the CIM array read controller
package cim_pkg;

   localparam int DW_DEF     = 24;
   localparam int AW_DEF     = 8;
   localparam int LW_DEF     = 4;

   // Legal range of the bank read latency (RE cycle to Q-valid cycle)
   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } rd_state_t;

endpackage

// File: rtl/cim_rd_bank_sel.sv
// rtl/cim_rd_bank_sel.sv - routes read enable/address to one bank and muxes its data back
module cim_rd_bank_sel #(
   parameter int DW = 24,
   parameter int AW = 8
) (
   input  logic          i_bank,
   input  logic          i_re,
   input  logic [AW-1:0] i_ra,
   input  logic [DW-1:0] i_q0,
   input  logic [DW-1:0] i_q1,
   output logic          o_re0,
   output logic [AW-1:0] o_ra0,
   output logic          o_re1,
   output logic [AW-1:0] o_ra1,
   output logic [DW-1:0] o_q
);

   logic w_sel0;
   logic w_sel1;

   assign w_sel0 = i_re & ~i_bank;
   assign w_sel1 = i_re &  i_bank;

   // Only the selected bank sees an enable; addresses are forced to zero whenever enable is low
   always_comb begin
      o_re0 = w_sel0;
      o_re1 = w_sel1;
      o_ra0 = w_sel0 ? i_ra : '0;
      o_ra1 = w_sel1 ? i_ra : '0;
   end

   // Return path follows the latched bank so the idle bank's Q never reaches the data register
   always_comb begin
      o_q = i_bank ? i_q1 : i_q0;
   end

endmodule

// File: rtl/cim_array_rd_ctrl.sv
// rtl/cim_array_rd_ctrl.sv - burst read controller for the two CIM SRAM banks
module cim_array_rd_ctrl
   import cim_pkg::*;
#(
   parameter int DW     = DW_DEF,
   parameter int AW     = AW_DEF,
   parameter int LW     = LW_DEF,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [AW-1:0] req_addr,
   input  logic [LW-1:0] req_len,
   input  logic          req_bank,
   output logic          RE0,
   output logic [AW-1:0] RA0,
   output logic          RE1,
   output logic [AW-1:0] RA1,
   input  logic [DW-1:0] Q0,
   input  logic [DW-1:0] Q1,
   output logic          rd_valid,
   input  logic          rd_ready,
   output logic [DW-1:0] rd_data,
   output logic          rd_last,
   output logic          busy
);

   if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
      $error("cim_array_rd_ctrl: RD_LAT out of range");
   end

   // Value of the latency counter in the WAIT cycle where Q is valid
   localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

   rd_state_t     r_state;
   logic [AW-1:0] r_addr;
   logic [LW-1:0] r_beats;
   logic          r_bank;
   logic [1:0]    r_lat;
   logic          r_re;
   logic          r_rd_valid;
   logic [DW-1:0] r_rd_data;
   logic          r_rd_last;
   logic          r_busy;
   logic          r_req_ready;
   logic [DW-1:0] w_q_sel;

   cim_rd_bank_sel #(
      .DW (DW),
      .AW (AW)
   ) u_bank_sel (
      .i_bank (r_bank),
      .i_re   (r_re),
      .i_ra   (r_addr),
      .i_q0   (Q0),
      .i_q1   (Q1),
      .o_re0  (RE0),
      .o_ra0  (RA0),
      .o_re1  (RE1),
      .o_ra1  (RA1),
      .o_q    (w_q_sel)
   );

   // Burst FSM: one outstanding bank read at a time, each beat held until the consumer takes it
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_addr      <= '0;
         r_beats     <= '0;
         r_bank      <= 1'b0;
         r_lat       <= '0;
         r_re        <= 1'b0;
         r_rd_valid  <= 1'b0;
         r_rd_data   <= '0;
         r_rd_last   <= 1'b0;
         r_busy      <= 1'b0;
         r_req_ready <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_addr      <= req_addr;
                  r_beats     <= req_len;
                  r_bank      <= req_bank;
                  r_re        <= 1'b1;
                  r_busy      <= 1'b1;
                  r_req_ready <= 1'b0;
                  r_state     <= ISSUE;
               end
            end
            ISSUE: begin
               r_re    <= 1'b0;
               r_lat   <= '0;
               r_state <= WAIT;
            end
            WAIT: begin
               if (r_lat == LAT_LAST) begin
                  r_rd_data  <= w_q_sel;
                  r_rd_valid <= 1'b1;
                  r_rd_last  <= (r_beats == '0);
                  r_state    <= HOLD;
               end else begin
                  r_lat <= r_lat + 2'd1;
               end
            end
            HOLD: begin
               if (rd_ready) begin
                  r_rd_valid <= 1'b0;
                  r_rd_last  <= 1'b0;
                  if (r_beats == '0) begin
                     r_busy      <= 1'b0;
                     r_req_ready <= 1'b1;
                     r_state     <= IDLE;
                  end else begin
                     r_addr  <= r_addr + 1'b1;
                     r_beats <= r_beats - 1'b1;
                     r_re    <= 1'b1;
                     r_state <= ISSUE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign req_ready = r_req_ready;
   assign busy      = r_busy;
   assign rd_valid  = r_rd_valid;
   assign rd_data   = r_rd_data;
   assign rd_last   = r_rd_last;

endmodule

// File: tb/tb_cim_array_rd_ctrl.sv
// tb/tb_cim_array_rd_ctrl.sv - scoreboard bench for cim_array_rd_ctrl
module tb_cim_array_rd_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          cyc = 0;
   int          n_chk = 0;
   int          n_err = 0;

   // instance A: RD_LAT = 1
   logic        req_valid = 1'b0, req_ready, req_bank = 1'b0;
   logic [7:0]  req_addr = '0;
   logic [3:0]  req_len = '0;
   logic        RE0, RE1, rd_valid, rd_last, busy;
   logic        rd_ready = 1'b1;
   logic [7:0]  RA0, RA1;
   logic [23:0] Q0, Q1, rd_data;
   logic [23:0] q0_m = '0, q1_m = '0, q0_ovr = '0;
   logic        q0_ovr_en = 1'b0;

   // instance B: RD_LAT = 3
   logic        b_req_valid = 1'b0, b_req_ready, b_req_bank = 1'b0;
   logic [7:0]  b_req_addr = '0;
   logic [3:0]  b_req_len = '0;
   logic        b_RE0, b_RE1, b_rd_valid, b_rd_last, b_busy;
   logic        b_rd_ready = 1'b1;
   logic [7:0]  b_RA0, b_RA1;
   logic [23:0] b_Q0, b_Q1, b_rd_data;
   logic [23:0] b_d1 = '0, b_d2 = '0, b_q0_m = '0, b_q1_m = '0;
   logic        b_v1 = 1'b0, b_v2 = 1'b0, b_s1 = 1'b0, b_s2 = 1'b0;

   logic [24:0] exp_data[$];
   logic [8:0]  exp_ra[$];
   int          hs_cyc[$];

   always #5 clk = ~clk;

   cim_array_rd_ctrl #(.DW(24), .AW(8), .LW(4), .RD_LAT(1)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_len(req_len), .req_bank(req_bank),
      .RE0(RE0), .RA0(RA0), .RE1(RE1), .RA1(RA1), .Q0(Q0), .Q1(Q1),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .rd_last(rd_last), .busy(busy)
   );

   cim_array_rd_ctrl #(.DW(24), .AW(8), .LW(4), .RD_LAT(3)) dut_lat3 (
      .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
      .req_addr(b_req_addr), .req_len(b_req_len), .req_bank(b_req_bank),
      .RE0(b_RE0), .RA0(b_RA0), .RE1(b_RE1), .RA1(b_RA1), .Q0(b_Q0), .Q1(b_Q1),
      .rd_valid(b_rd_valid), .rd_ready(b_rd_ready), .rd_data(b_rd_data),
      .rd_last(b_rd_last), .busy(b_busy)
   );

   function automatic logic [23:0] bank_word(input logic b, input logic [7:0] a);
      if (!b) return (a == 8'hA5) ? 24'hABCDEF : {8'hC0, a, ~a};
      else    return (a == 8'h5A) ? 24'h123456 : {8'h3A, ~a, a};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // bank models: A returns data one cycle after RE, B three cycles after RE
   always @(posedge clk) begin
      if (RE0) q0_m <= bank_word(1'b0, RA0);
      if (RE1) q1_m <= bank_word(1'b1, RA1);
      b_d1 <= b_RE1 ? bank_word(1'b1, b_RA1) : bank_word(1'b0, b_RA0);
      b_v1 <= b_RE0 | b_RE1;
      b_s1 <= b_RE1;
      b_d2 <= b_d1;
      b_v2 <= b_v1;
      b_s2 <= b_s1;
      if (b_v2) begin
         if (b_s2) b_q1_m <= b_d2;
         else      b_q0_m <= b_d2;
      end
   end

   assign Q0   = q0_ovr_en ? q0_ovr : q0_m;
   assign Q1   = q1_m;
   assign b_Q0 = b_q0_m;
   assign b_Q1 = b_q1_m;

   // monitor: bank port rules, RE/RA sequence and returned beats against the scoreboard
   always @(negedge clk) begin
      logic [24:0] e;
      logic [8:0]  ea;
      if (rst_n) begin
         chk("re_exclusive", {31'd0, RE0 & RE1}, 32'd0);
         if (!RE0) chk("ra0_idle_zero", {24'd0, RA0}, 32'd0);
         if (!RE1) chk("ra1_idle_zero", {24'd0, RA1}, 32'd0);
         if (RE0 | RE1) begin
            if (exp_ra.size() == 0) chk("re_unexpected", {31'd0, RE0 | RE1}, 32'd0);
            else begin
               ea = exp_ra.pop_front();
               chk("re_bank", {31'd0, RE1}, {31'd0, ea[8]});
               chk("re_addr", {24'd0, RE1 ? RA1 : RA0}, {24'd0, ea[7:0]});
            end
         end
         if (rd_valid && rd_ready) begin
            if (exp_data.size() == 0) chk("beat_unexpected", {31'd0, rd_valid}, 32'd0);
            else begin
               e = exp_data.pop_front();
               chk("rd_data", {8'd0, rd_data}, {8'd0, e[23:0]});
               chk("rd_last", {31'd0, rd_last}, {31'd0, e[24]});
            end
            hs_cyc.push_back(cyc);
         end
      end
   end

   task automatic issue_req(input logic b, input logic [7:0] a, input logic [3:0] l);
      req_valid = 1'b1;
      req_bank  = b;
      req_addr  = a;
      req_len   = l;
      for (int i = 0; i <= int'(l); i++) begin
         logic [7:0] ai;
         ai = a + 8'(i);
         exp_ra.push_back({b, ai});
         exp_data.push_back({(i == int'(l)), bank_word(b, ai)});
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_bank  = ~b;
      req_addr  = 8'($urandom);
      req_len   = 4'($urandom);
   endtask

   task automatic wait_idle(input string name, input int max);
      int k = 0;
      @(negedge clk);
      while (busy && k < max) begin
         @(negedge clk);
         k++;
      end
      chk(name, {31'd0, busy}, 32'd0);
   endtask

   task automatic check_reset_outputs(input string name);
      chk({name, "_RE0"}, {31'd0, RE0}, 32'd0);
      chk({name, "_RE1"}, {31'd0, RE1}, 32'd0);
      chk({name, "_RA0"}, {24'd0, RA0}, 32'd0);
      chk({name, "_RA1"}, {24'd0, RA1}, 32'd0);
      chk({name, "_rd_valid"}, {31'd0, rd_valid}, 32'd0);
      chk({name, "_rd_data"}, {8'd0, rd_data}, 32'd0);
      chk({name, "_rd_last"}, {31'd0, rd_last}, 32'd0);
      chk({name, "_busy"}, {31'd0, busy}, 32'd0);
      chk({name, "_req_ready"}, {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      int k;

      // 1: reset then single beat from bank 0
      q0_ovr_en = 1'b1;
      q0_ovr    = 24'hABCDEF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      issue_req(1'b0, 8'hA5, 4'd0);
      @(negedge clk);
      chk("t1_c1_RE0", {31'd0, RE0}, 32'd1);
      chk("t1_c1_RA0", {24'd0, RA0}, 32'hA5);
      chk("t1_c1_RE1", {31'd0, RE1}, 32'd0);
      chk("t1_c1_RA1", {24'd0, RA1}, 32'd0);
      @(negedge clk);
      chk("t1_c2_rd_valid", {31'd0, rd_valid}, 32'd0);
      @(negedge clk);
      chk("t1_c3_rd_valid", {31'd0, rd_valid}, 32'd1);
      chk("t1_c3_rd_data", {8'd0, rd_data}, 32'hABCDEF);
      chk("t1_c3_rd_last", {31'd0, rd_last}, 32'd1);
      @(negedge clk);
      chk("t1_c4_busy", {31'd0, busy}, 32'd0);
      chk("t1_c4_req_ready", {31'd0, req_ready}, 32'd1);

      // 2: bank 1 single beat while bank 0 drives all-ones
      q0_ovr = 24'hFFFFFF;
      @(posedge clk); #1;
      issue_req(1'b1, 8'h5A, 4'd0);
      wait_idle("t2_idle", 20);
      q0_ovr_en = 1'b0;

      // 3: four beats across the address wrap, period RD_LAT+2
      @(posedge clk); #1;
      n0 = hs_cyc.size();
      issue_req(1'b0, 8'hFE, 4'd3);
      wait_idle("t3_idle", 40);
      chk("t3_beats", 32'(hs_cyc.size() - n0), 32'd4);
      if (hs_cyc.size() - n0 == 4) begin
         for (int i = n0 + 1; i < n0 + 4; i++)
            chk("t3_period", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd3);
      end

      // 4: consumer stall with request noise while busy
      @(posedge clk); #1;
      rd_ready = 1'b0;
      issue_req(1'b1, 8'h10, 4'd1);
      k = 0;
      @(negedge clk);
      while (!rd_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      for (int i = 0; i < 5; i++) begin
         chk("t4_hold_valid", {31'd0, rd_valid}, 32'd1);
         chk("t4_hold_data", {8'd0, rd_data}, {8'd0, bank_word(1'b1, 8'h10)});
         chk("t4_hold_busy", {31'd0, busy}, 32'd1);
         chk("t4_hold_req_ready", {31'd0, req_ready}, 32'd0);
         @(posedge clk); #1;
         req_valid = ~req_valid;
         req_bank  = ~req_bank;
         req_addr  = 8'($urandom);
         @(negedge clk);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      rd_ready  = 1'b1;
      wait_idle("t4_idle", 30);

      // 5: reset during WAIT of beat 2
      @(posedge clk); #1;
      issue_req(1'b0, 8'h20, 4'd3);
      k = 0;
      @(negedge clk);
      while (!(rd_valid && rd_ready) && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("t5_first_beat", {31'd0, rd_valid}, 32'd1);
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b0;
      exp_data.delete();
      exp_ra.delete();
      @(negedge clk);
      chk("t5_wait_no_valid", {31'd0, rd_valid}, 32'd0);
      @(negedge clk);
      check_reset_outputs("t5_reset");
      @(negedge clk);
      chk("t5_no_re", {31'd0, RE0 | RE1}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      issue_req(1'b1, 8'h77, 4'd0);
      wait_idle("t5_after_idle", 20);

      // 6: RD_LAT=3 instance, single read
      @(posedge clk); #1;
      b_req_valid = 1'b1;
      b_req_bank  = 1'b0;
      b_req_addr  = 8'h33;
      b_req_len   = 4'd0;
      @(posedge clk); #1;
      b_req_valid = 1'b0;
      b_req_bank  = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         if (i == 1) begin
            chk("t6_RE0", {31'd0, b_RE0}, 32'd1);
            chk("t6_RA0", {24'd0, b_RA0}, 32'h33);
         end
         if (i < 5) chk("t6_early_valid", {31'd0, b_rd_valid}, 32'd0);
      end
      chk("t6_valid", {31'd0, b_rd_valid}, 32'd1);
      chk("t6_data", {8'd0, b_rd_data}, {8'd0, bank_word(1'b0, 8'h33)});
      chk("t6_last", {31'd0, b_rd_last}, 32'd1);
      @(negedge clk);
      chk("t6_idle", {31'd0, b_busy}, 32'd0);

      chk("sb_data_empty", 32'(exp_data.size()), 32'd0);
      chk("sb_ra_empty", 32'(exp_ra.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
